gray_code_converter: RTL and testbench



---
 rtl/gray_conv_pkg.sv | 15 +
 rtl/gray_code_converter_if.sv | 35 +++
 rtl/code_conv.sv | 29 ++
 rtl/gray_code_converter.sv | 130 +++++++++++++
 tb/tb_gray_code_converter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gray_conv_pkg.sv
// rtl/gray_conv_pkg.sv - shared types and defaults for the gray code converter
package gray_conv_pkg;

  localparam int GC_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CONV = 3'd2,
    XFER = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } gc_state_t;

endpackage

// File: rtl/gray_code_converter_if.sv
// rtl/gray_code_converter_if.sv - host-side request/result bundle of the converter
interface gray_code_converter_if
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH_DEFAULT
);

  logic             start;
  logic             convert;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             done;
  logic             busy;

  // Host side: issues requests, observes result and status
  modport master (
    output start,
    output convert,
    output data_in,
    input  data_out,
    input  done,
    input  busy
  );

  // Converter side
  modport slave (
    input  start,
    input  convert,
    input  data_in,
    output data_out,
    output done,
    output busy
  );

endinterface

// File: rtl/code_conv.sv
// rtl/code_conv.sv - combinational binary<->Gray conversion in both directions
module code_conv
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             acc;

  // mode=1: each Gray bit is the XOR of neighbouring binary bits.
  // mode=0: each binary bit is the running XOR of Gray bits from the MSB down.
  always_comb begin
    gray = din ^ (din >> 1);
    bin  = '0;
    acc  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ din[i];
      bin[i] = acc;
    end
    dout = mode ? gray : bin;
  end

endmodule

// File: rtl/gray_code_converter.sv
// rtl/gray_code_converter.sv - sequenced converter moving one word through R1..R4
module gray_code_converter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gray_code_converter_if.slave  bus,
  output logic                  R1_in,
  output logic                  R1_out,
  output logic                  R2_in,
  output logic                  R2_out,
  output logic                  R3_in,
  output logic                  R3_out,
  output logic                  R4_in,
  output logic                  R4_out
);

  gc_state_t        state_q;
  gc_state_t        state_d;

  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] r3_q;
  logic [WIDTH-1:0] r4_q;
  logic             mode_q;
  logic [WIDTH-1:0] conv_out;

  logic             done_o;
  logic             busy_o;

  code_conv #(
    .WIDTH(WIDTH)
  ) u_code_conv (
    .din  (r1_q),
    .mode (mode_q),
    .dout (conv_out)
  );

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore strobe decode; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    R1_in   = 1'b0;
    R1_out  = 1'b0;
    R2_in   = 1'b0;
    R2_out  = 1'b0;
    R3_in   = 1'b0;
    R3_out  = 1'b0;
    R4_in   = 1'b0;
    R4_out  = 1'b0;
    done_o  = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (bus.start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        R1_in   = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        R1_out  = 1'b1;
        R2_in   = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        R2_out  = 1'b1;
        R3_in   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        R3_out  = 1'b1;
        R4_in   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        R4_out  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Register transfers, each enabled by the strobe of the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      r4_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      if (R1_in) begin
        r1_q   <= bus.data_in;
        mode_q <= bus.convert;
      end
      if (R2_in) begin
        r2_q <= conv_out;
      end
      if (R3_in) begin
        r3_q <= r2_q;
      end
      if (R4_in) begin
        r4_q <= r3_q;
      end
    end
  end

  assign bus.data_out = r4_q;
  assign bus.done     = done_o;
  assign bus.busy     = busy_o;

endmodule

// File: tb/tb_gray_code_converter.sv
// tb/tb_gray_code_converter.sv - directed scoreboard bench for gray_code_converter
module tb_gray_code_converter;
  import gray_conv_pkg::*;

  localparam int W = GC_WIDTH_DEFAULT;

  // {R1_in,R1_out,R2_in,R2_out,R3_in,R3_out,R4_in,R4_out,done,busy} per cycle after E0
  localparam logic [9:0] EXP_STROBES [6] = '{
    10'b1000000001,
    10'b0110000001,
    10'b0001100001,
    10'b0000011001,
    10'b0000000111,
    10'b0000000000
  };

  logic clk = 1'b0;
  logic rst_n;
  logic R1_in, R1_out, R2_in, R2_out, R3_in, R3_out, R4_in, R4_out;

  gray_code_converter_if #(.WIDTH(W)) bus ();

  gray_code_converter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .R1_in  (R1_in),
    .R1_out (R1_out),
    .R2_in  (R2_in),
    .R2_out (R2_out),
    .R3_in  (R3_in),
    .R3_out (R3_out),
    .R4_in  (R4_in),
    .R4_out (R4_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int n_done;
  logic [W-1:0] sb[$];
  int           done_cycles[$];
  logic [W-1:0] exp_word;
  logic [W-1:0] d;

  wire [9:0] strobes = {R1_in, R1_out, R2_in, R2_out, R3_in, R3_out, R4_in, R4_out,
                        bus.done, bus.busy};

  always @(posedge clk) cycle++;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every done pulse pops one expected word
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cycles.push_back(cycle);
      if (sb.size() == 0) begin
        check("done_without_request", 32'(bus.done), 32'(0));
      end else begin
        exp_word = sb.pop_front();
        check("data_out", 32'(bus.data_out), 32'(exp_word));
      end
    end
  end

  task automatic run_conv(input logic [W-1:0] din, input logic m, input logic [W-1:0] e,
                          input bit poke);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.convert = m;
    bus.data_in = din;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("strobes_k%0d", k), 32'(strobes), 32'(EXP_STROBES[k]));
      if (k == 1) begin
        bus.data_in = W'($urandom);
        bus.convert = ~m;
      end
      if (poke && k == 2) begin
        bus.start   = 1'b1;
        bus.data_in = ~din;
      end
      if (poke && k == 3) bus.start = 1'b0;
    end
    check("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.convert = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", 32'(strobes), 32'(0));
    check("reset_data_out", 32'(bus.data_out), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_conv(8'b11001010, 1'b1, 8'b10101111, 1'b0);
    run_conv(8'b10101111, 1'b0, 8'b11001010, 1'b0);
    run_conv(8'h00, 1'b1, 8'h00, 1'b0);
    run_conv(8'hFF, 1'b1, 8'h80, 1'b0);
    run_conv(8'h80, 1'b0, 8'hFF, 1'b0);
    run_conv(8'h3C, 1'b1, 8'h22, 1'b1);

    // Abort in CONV
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.convert = 1'b1;
    bus.data_in = 8'h5A;
    sb.push_back(b2g(8'h5A));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'(strobes), 32'(0));
    check("abort_data_out", 32'(bus.data_out), 32'(0));
    sb.delete();
    n_done = done_cycles.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("no_done_after_abort", 32'(done_cycles.size()), 32'(n_done));
    check("idle_after_abort", 32'(strobes), 32'(0));

    // Start held for 20 cycles: LOAD every 6 cycles
    n_done = done_cycles.size();
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.convert = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      d = W'($urandom);
      bus.data_in = d;
      if (i % 6 == 0) sb.push_back(b2g(d));
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("held_done_count", 32'(done_cycles.size() - n_done), 32'(4));
    for (int j = 1; j < 4 && n_done + j < done_cycles.size(); j++) begin
      check("held_done_spacing", 32'(done_cycles[n_done + j] - done_cycles[n_done + j - 1]),
            32'(6));
    end
    check("held_sb_drained", 32'(sb.size()), 32'(0));

    // Round trip of every value
    for (int v = 0; v < (1 << W); v++) begin
      run_conv(W'(v), 1'b1, b2g(W'(v)), 1'b0);
      run_conv(b2g(W'(v)), 1'b0, W'(v), 1'b0);
    end

    check("final_sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
